// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: state encoding and frame constants.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        GAP  = 2'b10
    } arb_state_t;

    // Oversample ticks per bit and bits per frame (start + 8 data + stop).
    localparam int TICKS_PER_BIT = 16;
    localparam int FRAME_BITS    = 10;

endpackage

// File: rtl/uart_rr_pick.sv
// Rotate-priority picker: first set request bit searching from ptr upward with wrap.
module uart_rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] winner,
    output logic          any_valid
);

    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= N) sum = sum - N;
        return IW'(sum);
    endfunction

    // Walk offsets from farthest to nearest so the nearest set bit to ptr wins.
    always_comb begin
        winner = ptr;
        for (int off = N - 1; off >= 0; off--) begin
            if (valid[wrap_add(ptr, off)]) winner = wrap_add(ptr, off);
        end
    end

    assign any_valid = |valid;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N byte producers,
// with burst lock, optional inter-frame gap in baud ticks and a frame watchdog.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N         = 4,
    parameter int GAP_TICKS = 0,
    parameter int TIMEOUT   = 200000
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           tick,
    input  logic [N-1:0]   req_valid,
    input  logic [8*N-1:0] req_data,
    input  logic [N-1:0]   req_lock,
    output logic [N-1:0]   req_ack,
    output logic [N-1:0]   req_done,
    output logic [7:0]     tx_data,
    output logic           tx_start,
    input  logic           tx_done_tick,
    output logic           busy,
    output logic           err_timeout,
    input  logic           err_clr
);

    localparam int IW  = $clog2(N);
    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam logic [N-1:0] ONE = 1;

    arb_state_t      state, state_nxt;
    logic [IW-1:0]   ptr, ptr_nxt;
    logic [IW-1:0]   owner, owner_nxt;
    logic            lock_pend, lock_nxt;
    logic [7:0]      gap_cnt, gap_nxt;
    logic [WDW-1:0]  wd, wd_nxt;
    logic [7:0]      data_nxt;
    logic            start_nxt;
    logic [N-1:0]    ack_nxt, done_nxt;
    logic            err_nxt;

    logic [IW-1:0]   pick_w, grant_w;
    logic            any_valid, lock_hit;

    uart_rr_pick #(.N(N), .IW(IW)) u_pick (
        .valid     (req_valid),
        .ptr       (ptr),
        .winner    (pick_w),
        .any_valid (any_valid)
    );

    // A burst owner that is still requesting keeps the transmitter ahead of the rotation.
    assign lock_hit = lock_pend && req_valid[owner];
    assign grant_w  = lock_hit ? owner : pick_w;

    // Next-state and registered-output values for every state.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        owner_nxt = owner;
        lock_nxt  = lock_pend;
        gap_nxt   = gap_cnt;
        wd_nxt    = wd;
        data_nxt  = tx_data;
        start_nxt = 1'b0;
        ack_nxt   = '0;
        done_nxt  = '0;
        err_nxt   = err_timeout & ~err_clr;

        case (state)
            IDLE: begin
                if (any_valid) begin
                    data_nxt  = req_data[{grant_w, 3'b000} +: 8];
                    start_nxt = 1'b1;
                    ack_nxt   = ONE << grant_w;
                    owner_nxt = grant_w;
                    wd_nxt    = '0;
                    lock_nxt  = 1'b0;
                    if (!lock_hit)
                        ptr_nxt = (pick_w == IW'(N - 1)) ? '0 : pick_w + IW'(1);
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (tx_done_tick) begin
                    done_nxt  = ONE << owner;
                    lock_nxt  = req_lock[owner] & req_valid[owner];
                    wd_nxt    = '0;
                    state_nxt = (GAP_TICKS > 0) ? GAP : IDLE;
                end else if (wd == WDW'(TIMEOUT - 1)) begin
                    err_nxt   = 1'b1;
                    lock_nxt  = 1'b0;
                    wd_nxt    = '0;
                    state_nxt = IDLE;
                end else begin
                    wd_nxt = wd + WDW'(1);
                end
            end
            GAP: begin
                if (tick) begin
                    if (gap_cnt == 8'(GAP_TICKS - 1)) begin
                        gap_nxt   = '0;
                        state_nxt = IDLE;
                    end else begin
                        gap_nxt = gap_cnt + 8'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, counters and all outputs registered; reset clears everything at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            ptr         <= '0;
            owner       <= '0;
            lock_pend   <= 1'b0;
            gap_cnt     <= '0;
            wd          <= '0;
            tx_data     <= 8'h00;
            tx_start    <= 1'b0;
            req_ack     <= '0;
            req_done    <= '0;
            err_timeout <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            owner       <= owner_nxt;
            lock_pend   <= lock_nxt;
            gap_cnt     <= gap_nxt;
            wd          <= wd_nxt;
            tx_data     <= data_nxt;
            tx_start    <= start_nxt;
            req_ack     <= ack_nxt;
            req_done    <= done_nxt;
            err_timeout <= err_nxt;
            busy        <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed and randomized frames against
// a transaction-level arbitration model; second instance exercises the gap.
module tb_uart_tx_arbiter;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        reset, reset_g;
    logic        tick;
    logic [3:0]  req_valid, req_lock;
    logic [31:0] req_data;
    logic        tx_done_tick, err_clr;

    logic [3:0]  req_ack, req_done, req_ack_g, req_done_g;
    logic [7:0]  tx_data, tx_data_g;
    logic        tx_start, busy, err_timeout;
    logic        tx_start_g, busy_g, err_timeout_g;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Reference model: rotation pointer, last owner, pending burst lock.
    int m_ptr   = 0;
    int m_owner = 0;
    bit m_lock  = 1'b0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N(N), .GAP_TICKS(0), .TIMEOUT(50)) dut (
        .clk(clk), .reset(reset), .tick(tick),
        .req_valid(req_valid), .req_data(req_data), .req_lock(req_lock),
        .req_ack(req_ack), .req_done(req_done),
        .tx_data(tx_data), .tx_start(tx_start), .tx_done_tick(tx_done_tick),
        .busy(busy), .err_timeout(err_timeout), .err_clr(err_clr)
    );

    uart_tx_arbiter #(.N(N), .GAP_TICKS(16), .TIMEOUT(1000)) dut_g (
        .clk(clk), .reset(reset_g), .tick(tick),
        .req_valid(req_valid), .req_data(req_data), .req_lock(req_lock),
        .req_ack(req_ack_g), .req_done(req_done_g),
        .tx_data(tx_data_g), .tx_start(tx_start_g), .tx_done_tick(tx_done_tick),
        .busy(busy_g), .err_timeout(err_timeout_g), .err_clr(err_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_first(input logic [3:0] v);
        for (int i = 0; i < N; i++)
            if (v[(m_ptr + i) % N]) return (m_ptr + i) % N;
        return -1;
    endfunction

    // One complete frame on the gap-free instance; called at a negedge.
    task automatic do_frame(input logic [3:0] v, input logic [3:0] lk,
                            input logic [31:0] d, input int hold);
        int w;
        bit by_lock;
        by_lock = m_lock && v[m_owner];
        w = by_lock ? m_owner : rr_first(v);
        req_valid = v;
        req_lock  = lk;
        req_data  = d;
        @(negedge clk);
        chk("start", tx_start, 1);
        chk("ack", req_ack, 32'(1) << w);
        chk("data", tx_data, d[8*w +: 8]);
        chk("busy", busy, 1);
        if (!by_lock) m_ptr = (w + 1) % N;
        m_owner = w;
        m_lock  = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("start_low", {req_ack, tx_start}, 0);
            chk("data_hold", tx_data, d[8*w +: 8]);
        end
        tx_done_tick = 1'b1;
        @(negedge clk);
        tx_done_tick = 1'b0;
        chk("done", req_done, 32'(1) << w);
        chk("busy_end", busy, 0);
        m_lock = lk[w] && v[w];
        req_valid = 4'b0000;
    endtask

    initial begin
        int cnt;
        int guard;
        logic [31:0] d;
        reset = 1'b0; reset_g = 1'b0; tick = 1'b0;
        req_valid = '0; req_lock = '0; req_data = '0;
        tx_done_tick = 1'b0; err_clr = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_outs", {req_ack, req_done, tx_data, tx_start, busy, err_timeout}, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_busy", busy, 0);

        // Single request, then done pulse lasts one cycle
        do_frame(4'b0010, 4'b0000, 32'h0000A500, 1);
        @(negedge clk);
        chk("done_1cyc", req_done, 0);

        // Bring pointer to 0, then all four valid: 0,1,2,3,0
        do_frame(4'b1000, 4'b0000, $urandom, 0);
        for (int i = 0; i < 5; i++) do_frame(4'b1111, 4'b0000, $urandom, $urandom_range(0, 3));

        // Lock burst: 2,2,2 then 0
        do_frame(4'b0101, 4'b0100, $urandom, 2);
        do_frame(4'b0101, 4'b0100, $urandom, 1);
        do_frame(4'b0101, 4'b0000, $urandom, 0);
        do_frame(4'b0101, 4'b0000, $urandom, 1);

        // Randomized traffic with random locks
        for (int i = 0; i < 24; i++)
            do_frame(4'($urandom_range(1, 15)), 4'($urandom_range(0, 15)),
                     $urandom, $urandom_range(0, 5));

        // done outside BUSY is ignored
        tx_done_tick = 1'b1;
        @(negedge clk);
        tx_done_tick = 1'b0;
        chk("stray_done", {req_done, busy}, 0);

        // Watchdog: no done; clear in the firing cycle loses to set
        if (!(m_lock && m_owner == 0)) m_ptr = 1;
        req_valid = 4'b0001; req_lock = 4'b0000; req_data = $urandom;
        @(negedge clk);
        chk("wd_start", tx_start, 1);
        req_valid = 4'b0000;
        repeat (49) @(negedge clk);
        chk("wd_early", {busy, err_timeout}, 2'b10);
        err_clr = 1'b1;
        @(negedge clk);
        chk("wd_fire", {busy, err_timeout}, 2'b01);
        chk("wd_nodone", req_done, 0);
        @(negedge clk);
        err_clr = 1'b0;
        chk("wd_clr", err_timeout, 0);
        m_owner = 0; m_lock = 1'b0;

        // Done in the cycle the watchdog would fire: done wins
        req_valid = 4'b0001;
        @(negedge clk);
        chk("wd2_start", tx_start, 1);
        m_ptr = 1;
        req_valid = 4'b0000;
        repeat (49) @(negedge clk);
        tx_done_tick = 1'b1;
        @(negedge clk);
        tx_done_tick = 1'b0;
        chk("race_done", req_done, 4'b0001);
        chk("race_noerr", {busy, err_timeout}, 0);

        // Asynchronous reset between edges in BUSY
        do_frame(4'b0010, 4'b0000, $urandom, 0);
        req_valid = 4'b0100;
        @(negedge clk);
        chk("pre_rst_start", tx_start, 1);
        #2 reset = 1'b0;
        #1;
        chk("async_rst", {req_ack, req_done, tx_data, tx_start, busy, err_timeout}, 0);
        @(negedge clk);
        reset = 1'b1;
        m_ptr = 0; m_owner = 0; m_lock = 1'b0;
        do_frame(4'b1111, 4'b0000, $urandom, 1);

        // Gap instance: exactly 16 ticks between done and next start
        reset = 1'b0;
        reset_g = 1'b1;
        d = $urandom;
        req_valid = 4'b0011; req_lock = 4'b0000; req_data = d;
        @(negedge clk);
        chk("g_start", {req_ack_g, tx_start_g}, 5'b00011);
        chk("g_data", tx_data_g, d[7:0]);
        repeat (2) @(negedge clk);
        tx_done_tick = 1'b1;
        tick = 1'b1;
        @(negedge clk);
        tx_done_tick = 1'b0;
        chk("g_done", req_done_g, 4'b0001);
        cnt = 0;
        guard = 0;
        while (cnt < 16 && guard < 400) begin
            chk("g_hold", {busy_g, tx_start_g}, 2'b10);
            tick = ($urandom_range(0, 2) == 0);
            if (tick) cnt++;
            guard++;
            @(negedge clk);
        end
        tick = 1'b0;
        chk("g_bound", cnt, 16);
        chk("g_idle", {busy_g, tx_start_g}, 2'b00);
        @(negedge clk);
        chk("g_start2", {req_ack_g, tx_start_g}, 5'b00101);
        chk("g_data2", tx_data_g, d[15:8]);
        req_valid = 4'b0000;
        tx_done_tick = 1'b1;
        @(negedge clk);
        tx_done_tick = 1'b0;
        chk("g_done2", req_done_g, 4'b0010);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
